sr04_controller: RTL and testbench
==================================

SR04_CONTROLLER -- requirements
Module: sr04_controller

Interface
REQ-001 Parameter CLK_FREQ, 100_000_000, system clock frequency in Hz.
REQ-002 Parameter TRIG_US, 10, trigger pulse width in microseconds.
REQ-003 Parameter TIMEOUT_US, 30_000, maximum wait per phase (echo-rise wait, echo-high measure) in microseconds.
REQ-004 clk  input  1  system clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; 0 resets all state immediately.
REQ-006 start  input  1  measurement request, sampled each clk; one-cycle pulse expected.
REQ-007 echo  input  1  SR04 echo pin, asynchronous to clk.
REQ-008 trig  output  1  SR04 trigger pin, registered.
REQ-009 distance  output  12  last valid distance in cm, binary; feeds display data bits [11:0].
REQ-010 dist_valid  output  1  one-cycle pulse when distance updates.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 timeout_err  output  1  sticky flag, last measurement timed out.

Function
REQ-013 echo SHALL pass a 2-flop synchronizer; all echo decisions use the synchronized value, giving 2-cycle input latency.
REQ-014 Rising/falling echo edges SHALL be detected by comparing synchronized echo with its 1-cycle-delayed copy.
REQ-015 A microsecond tick SHALL be generated by a counter of CLK_FREQ/1_000_000 cycles, cleared on every state transition, so each state starts with a full microsecond.
REQ-016 FSM states: IDLE, TRIG, WAIT_ECHO, MEASURE, DONE.
REQ-017 IDLE: start=1 -> TRIG on next edge, timeout_err cleared on same edge; start=0 -> stay.
REQ-018 TRIG: trig=1 for exactly TRIG_US ticks (1000 clk at defaults), then -> WAIT_ECHO with trig=0.
REQ-019 WAIT_ECHO: echo rising edge -> MEASURE; TIMEOUT_US ticks without edge -> IDLE with timeout_err=1.
REQ-020 MEASURE: 6-bit sub-counter counts ticks 0..57; at wrap to 0 the distance accumulator increments by 1 (integer echo_us/58, floor).
REQ-021 MEASURE: echo falling edge -> DONE; TIMEOUT_US ticks with echo still high -> IDLE with timeout_err=1, distance unchanged.
REQ-022 Distance accumulator SHALL saturate at 4095 and never wrap.
REQ-023 DONE: distance <= accumulator, dist_valid=1 for exactly this one cycle, then -> IDLE.
REQ-024 start asserted outside IDLE SHALL be ignored, not queued.
REQ-025 Echo already high on entry to WAIT_ECHO SHALL NOT count as a rising edge; only a 0->1 transition is accepted.
REQ-026 Echo glitches in IDLE, TRIG or DONE SHALL have no effect.
REQ-027 distance SHALL hold its value across timeouts and new measurements until the next DONE.

Reset
REQ-028 reset=0 SHALL force: state IDLE, trig=0, distance=0, dist_valid=0, busy=0, timeout_err=0, all counters and synchronizer flops 0.
REQ-029 reset asserted mid-measurement SHALL abort immediately with no dist_valid pulse; after release the block waits in IDLE for a new start.

Verification
REQ-030 Reset: reset=0 for 5 cycles, echo toggling -> all outputs 0, busy=0 throughout.
REQ-031 Trigger: start pulse -> busy=1 next cycle, trig high exactly 1000 cycles, then low.
REQ-032 Echo 580 us after trigger end -> distance=10, dist_valid one cycle; echo 1160 us -> distance=20; echo 57 us -> distance=0 with dist_valid.
REQ-033 No echo -> after 30_000 us in WAIT_ECHO: timeout_err=1, busy=0, distance keeps prior value 20; next start clears timeout_err.
REQ-034 Echo held high >30_000 us -> timeout_err=1, no dist_valid; start pulses during TRIG/MEASURE ignored (exactly one trig pulse observed).
REQ-035 reset=0 during MEASURE at 300 us -> trig=0, distance=0, no dist_valid; subsequent start + 116 us echo -> distance=2.

Source files
------------

// File: rtl/sr04_controller.sv
// HC-SR04 ultrasonic ranging controller: trigger pulse, echo width capture,
// conversion to centimetres (echo_us / 58) with per-phase timeouts.
//
// state       | meaning
// ------------+----------------------------------------------------------
// S_IDLE      | waiting for start
// S_TRIG      | driving trig high for TRIG_US microseconds
// S_WAIT_ECHO | waiting for a 0->1 echo transition, bounded by TIMEOUT_US
// S_MEASURE   | echo high, accumulating centimetres, bounded by TIMEOUT_US
// S_DONE      | latch accumulator into distance, pulse dist_valid
module sr04_controller #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned TRIG_US    = 10,
  parameter int unsigned TIMEOUT_US = 30_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        echo,
  output logic        trig,
  output logic [11:0] distance,
  output logic        dist_valid,
  output logic        busy,
  output logic        timeout_err
);

  localparam int unsigned TICK_DIV = (CLK_FREQ / 1_000_000 > 0) ? CLK_FREQ / 1_000_000 : 1;
  localparam int unsigned US_W     = $clog2(TICK_DIV + 1);
  localparam int unsigned PH_MAX   = (TRIG_US > TIMEOUT_US) ? TRIG_US : TIMEOUT_US;
  localparam int unsigned PH_W     = $clog2(PH_MAX + 1);

  localparam logic [US_W-1:0] US_LOAD   = US_W'(TICK_DIV - 1);
  localparam logic [PH_W-1:0] TRIG_LOAD = PH_W'(TRIG_US - 1);
  localparam logic [PH_W-1:0] TOUT_LOAD = PH_W'(TIMEOUT_US - 1);
  localparam logic [5:0]      SUB_LAST  = 6'd57;
  localparam logic [11:0]     DIST_MAX  = 12'hFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_ECHO,
    S_MEASURE,
    S_DONE
  } state_t;

  state_t           state, state_next;
  logic             echo_s1, echo_s2, echo_d;
  logic             echo_rise, echo_fall;
  logic [US_W-1:0]  us_cnt;
  logic [PH_W-1:0]  ph_cnt;
  logic [5:0]       sub_cnt;
  logic [11:0]      acc;
  logic             tick, phase_end, set_timeout;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      echo_s1 <= 1'b0;
      echo_s2 <= 1'b0;
      echo_d  <= 1'b0;
    end else begin
      echo_s1 <= echo;
      echo_s2 <= echo_s1;
      echo_d  <= echo_s2;
    end
  end

  assign echo_rise = echo_s2 & ~echo_d;
  assign echo_fall = ~echo_s2 & echo_d;
  assign tick      = (us_cnt == '0);
  assign phase_end = tick && (ph_cnt == '0);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    set_timeout = 1'b0;
    case (state)
      S_IDLE:      if (start) state_next = S_TRIG;
      S_TRIG:      if (phase_end) state_next = S_WAIT_ECHO;
      S_WAIT_ECHO: begin
        if (echo_rise) begin
          state_next = S_MEASURE;
        end else if (phase_end) begin
          state_next  = S_IDLE;
          set_timeout = 1'b1;
        end
      end
      S_MEASURE: begin
        if (echo_fall) begin
          state_next = S_DONE;
        end else if (phase_end) begin
          state_next  = S_IDLE;
          set_timeout = 1'b1;
        end
      end
      S_DONE:      state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  // Both timers restart on every transition so each state sees whole microseconds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      us_cnt <= '0;
      ph_cnt <= '0;
    end else if (state_next != state) begin
      us_cnt <= US_LOAD;
      case (state_next)
        S_TRIG:                 ph_cnt <= TRIG_LOAD;
        S_WAIT_ECHO, S_MEASURE: ph_cnt <= TOUT_LOAD;
        default:                ph_cnt <= '0;
      endcase
    end else begin
      us_cnt <= tick ? US_LOAD : us_cnt - US_W'(1);
      if (tick && ph_cnt != '0) ph_cnt <= ph_cnt - PH_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sub_cnt <= '0;
      acc     <= '0;
    end else if (state == S_WAIT_ECHO) begin
      sub_cnt <= '0;
      acc     <= '0;
    end else if (state == S_MEASURE && tick) begin
      if (sub_cnt == SUB_LAST) begin
        sub_cnt <= '0;
        if (acc != DIST_MAX) acc <= acc + 12'd1;
      end else begin
        sub_cnt <= sub_cnt + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trig        <= 1'b0;
      distance    <= '0;
      dist_valid  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      trig       <= (state_next == S_TRIG);
      dist_valid <= (state == S_DONE);
      if (state == S_DONE) distance <= acc;
      if (state == S_IDLE && start) timeout_err <= 1'b0;
      else if (set_timeout)         timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sr04_controller.sv
// Directed bench for sr04_controller, run at 4 cycles per microsecond with a
// 2000 us timeout so every scenario stays short.
module tb_sr04_controller;

  localparam int unsigned CLK_FREQ   = 4_000_000;
  localparam int unsigned TRIG_US    = 10;
  localparam int unsigned TIMEOUT_US = 2000;
  localparam int          CPU        = 4;

  logic        clk, reset, start, echo;
  logic        trig, dist_valid, busy, timeout_err;
  logic [11:0] distance;

  int n_checks = 0;
  int n_fail   = 0;
  int trig_rises = 0;
  int valid_pulses = 0;
  logic trig_q = 1'b0;

  sr04_controller #(
    .CLK_FREQ  (CLK_FREQ),
    .TRIG_US   (TRIG_US),
    .TIMEOUT_US(TIMEOUT_US)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .echo       (echo),
    .trig       (trig),
    .distance   (distance),
    .dist_valid (dist_valid),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (trig === 1'b1 && trig_q !== 1'b1) trig_rises++;
    if (dist_valid === 1'b1) valid_pulses++;
    trig_q = trig;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_trig_low(output int cnt);
    cnt = 0;
    while (trig === 1'b1 && cnt < 200) begin
      step();
      cnt++;
    end
  endtask

  task automatic measure(input string tag, input int width_us, input int exp_dist);
    int cnt;
    pulse_start();
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_terr_clr"}, 32'(timeout_err), 32'd0);
    wait_trig_low(cnt);
    check({tag, "_trig_len"}, 32'(cnt), 32'(TRIG_US * CPU));
    repeat (5) step();
    echo = 1'b1;
    repeat (width_us * CPU) step();
    echo = 1'b0;
    cnt = 0;
    while (dist_valid !== 1'b1 && cnt < 20) begin
      step();
      cnt++;
    end
    check({tag, "_valid"}, 32'(dist_valid), 32'd1);
    check({tag, "_dist"}, 32'(distance), 32'(exp_dist));
    step();
    check({tag, "_valid_1cyc"}, 32'(dist_valid), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int cnt, v0, tr0;
    reset = 1'b0;
    start = 1'b0;
    echo  = 1'b0;

    for (int i = 0; i < 5; i++) begin
      echo = ~echo;
      step();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_trig", 32'(trig), 32'd0);
      check("rst_valid", 32'(dist_valid), 32'd0);
      check("rst_dist", 32'(distance), 32'd0);
      check("rst_terr", 32'(timeout_err), 32'd0);
    end
    echo  = 1'b0;
    reset = 1'b1;
    repeat (3) step();

    measure("m580", 580, 10);
    repeat (3) step();
    measure("m1160", 1160, 20);

    // echo activity while idle must not start anything
    for (int i = 0; i < 6; i++) begin
      echo = ~echo;
      step();
    end
    echo = 1'b0;
    repeat (4) step();
    check("glitch_busy", 32'(busy), 32'd0);
    check("glitch_trig", 32'(trig), 32'd0);

    // echo already high entering WAIT_ECHO, then no rising edge -> timeout
    v0 = valid_pulses;
    pulse_start();
    repeat (10) step();
    echo = 1'b1;
    wait_trig_low(cnt);
    check("wt_trig_len", 32'(cnt), 32'd30);
    repeat (100) step();
    check("wt_still_wait", 32'(busy), 32'd1);
    echo = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 9000) begin
      step();
      cnt++;
    end
    check("wt_timeout_cycles", 32'(cnt), 32'd7900);
    check("wt_busy", 32'(busy), 32'd0);
    check("wt_terr", 32'(timeout_err), 32'd1);
    check("wt_dist_kept", 32'(distance), 32'd20);
    check("wt_no_valid", 32'(valid_pulses - v0), 32'd0);

    measure("m57", 57, 0);

    // echo stuck high, extra starts during TRIG and MEASURE
    v0  = valid_pulses;
    tr0 = trig_rises;
    pulse_start();
    repeat (10) step();
    pulse_start();
    wait_trig_low(cnt);
    check("ms_trig_len", 32'(cnt), 32'd29);
    repeat (5) step();
    echo = 1'b1;
    repeat (400) step();
    pulse_start();
    cnt = 0;
    while (busy === 1'b1 && cnt < 9000) begin
      step();
      cnt++;
    end
    check("ms_busy", 32'(busy), 32'd0);
    check("ms_terr", 32'(timeout_err), 32'd1);
    check("ms_no_valid", 32'(valid_pulses - v0), 32'd0);
    check("ms_dist_kept", 32'(distance), 32'd0);
    echo = 1'b0;
    repeat (20) step();
    check("ms_one_trig", 32'(trig_rises - tr0), 32'd1);
    check("ms_not_queued", 32'(busy), 32'd0);

    // reset in the middle of a measurement
    v0 = valid_pulses;
    pulse_start();
    wait_trig_low(cnt);
    repeat (5) step();
    echo = 1'b1;
    repeat (300 * CPU) step();
    check("ab_measuring", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("ab_trig", 32'(trig), 32'd0);
    check("ab_dist", 32'(distance), 32'd0);
    check("ab_valid", 32'(dist_valid), 32'd0);
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_terr", 32'(timeout_err), 32'd0);
    step();
    echo = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    repeat (3) step();
    check("ab_idle", 32'(busy), 32'd0);
    check("ab_no_valid", 32'(valid_pulses - v0), 32'd0);
    measure("m116", 116, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
